// File: rtl/ip_oklab_pkg.sv
// Shared definitions for the RGB->LMS converter front end: arbiter FSM encoding,
// latency bound, error bit positions and the in-flight pixel tag.
package ip_oklab_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam int CVT_LAT_MAX = 4;

  localparam int ERR_TAG  = 0;
  localparam int ERR_LONG = 1;

  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;

endpackage

// File: rtl/ip_rgb2lms_tagq.sv
// Delay line of {valid, owner} tags that tracks pixels through the issue
// register and the converter so responses can be routed back.
module ip_rgb2lms_tagq
  import ip_oklab_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [STAGES:1] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], tag_in};
  end

  assign tag_out = vld_pipe[STAGES];

endmodule

// File: rtl/ip_rgb2lms_arb.sv
// Burst-locked round-robin arbiter sharing one ip_rgb2lms converter between two
// pixel requesters; drives converter framing and routes L/M/S back to the owner.
module ip_rgb2lms_arb
  import ip_oklab_pkg::*;
#(
  parameter int CIW       = 8,
  parameter int COW       = 12,
  parameter int CVT_LAT   = 1,
  parameter int MAX_BURST = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_req0_vld,
  output logic           o_req0_rdy,
  input  logic           i_req0_last,
  input  logic [CIW-1:0] i_req0_r,
  input  logic [CIW-1:0] i_req0_g,
  input  logic [CIW-1:0] i_req0_b,
  input  logic           i_req1_vld,
  output logic           o_req1_rdy,
  input  logic           i_req1_last,
  input  logic [CIW-1:0] i_req1_r,
  input  logic [CIW-1:0] i_req1_g,
  input  logic [CIW-1:0] i_req1_b,
  output logic [CIW-1:0] o_cvt_r,
  output logic [CIW-1:0] o_cvt_g,
  output logic [CIW-1:0] o_cvt_b,
  output logic           o_cvt_hstr,
  output logic           o_cvt_hend,
  output logic           o_cvt_href,
  input  logic [COW-1:0] i_cvt_l,
  input  logic [COW-1:0] i_cvt_m,
  input  logic [COW-1:0] i_cvt_s,
  input  logic           i_cvt_href,
  output logic           o_rsp0_vld,
  output logic           o_rsp1_vld,
  output logic [COW-1:0] o_rsp_l,
  output logic [COW-1:0] o_rsp_m,
  output logic [COW-1:0] o_rsp_s,
  input  logic           i_err_clr,
  output logic [1:0]     o_err
);

  localparam int CW     = $clog2(MAX_BURST + 1);
  localparam int STAGES = 1 + CVT_LAT;

  logic [1:0]    state, state_nxt;
  logic          last_gnt;
  logic [CW-1:0] beat_cnt;
  logic          acc0, acc1, acc, own, last_beat, burst_end;
  logic          other_vld, own_vld;
  logic          err_tag_set, err_long_set;
  tag_t          tag_in, tag_out;

  // In IDLE rdy follows vld with the tie going away from last_gnt;
  // once granted, rdy is a pure function of state.
  always_comb begin
    o_req0_rdy = 1'b0;
    o_req1_rdy = 1'b0;
    case (state)
      ST_IDLE: begin
        o_req0_rdy = i_req0_vld & (~i_req1_vld | last_gnt);
        o_req1_rdy = i_req1_vld & (~i_req0_vld | ~last_gnt);
      end
      ST_GNT0: o_req0_rdy = 1'b1;
      ST_GNT1: o_req1_rdy = 1'b1;
      default: ;
    endcase
  end

  assign acc0      = i_req0_vld & o_req0_rdy;
  assign acc1      = i_req1_vld & o_req1_rdy;
  assign acc       = acc0 | acc1;
  assign own       = acc1;
  assign last_beat = acc1 ? i_req1_last : i_req0_last;
  assign burst_end = acc & last_beat;
  assign other_vld = own ? i_req0_vld : i_req1_vld;
  assign own_vld   = own ? i_req1_vld : i_req0_vld;

  // At burst end the waiting requester is preferred, enabling zero-bubble handoff.
  always_comb begin
    state_nxt = state;
    if (burst_end) begin
      if (other_vld)    state_nxt = own ? ST_GNT0 : ST_GNT1;
      else if (own_vld) state_nxt = own ? ST_GNT1 : ST_GNT0;
      else              state_nxt = ST_IDLE;
    end else if (acc) begin
      state_nxt = own ? ST_GNT1 : ST_GNT0;
    end else if (state == 2'd3) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (burst_end) last_gnt <= own;
    end
  end

  // beat_cnt==0 marks the first beat of a burst; it saturates at MAX_BURST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  beat_cnt <= '0;
    else if (burst_end)                          beat_cnt <= '0;
    else if (acc && beat_cnt != CW'(MAX_BURST))  beat_cnt <= beat_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cvt_r    <= '0;
      o_cvt_g    <= '0;
      o_cvt_b    <= '0;
      o_cvt_hstr <= 1'b0;
      o_cvt_hend <= 1'b0;
      o_cvt_href <= 1'b0;
    end else begin
      o_cvt_href <= acc;
      o_cvt_hstr <= acc & (beat_cnt == '0);
      o_cvt_hend <= burst_end;
      if (acc) begin
        o_cvt_r <= own ? i_req1_r : i_req0_r;
        o_cvt_g <= own ? i_req1_g : i_req0_g;
        o_cvt_b <= own ? i_req1_b : i_req0_b;
      end
    end
  end

  assign tag_in.vld = acc;
  assign tag_in.own = own;

  ip_rgb2lms_tagq #(.STAGES(STAGES)) u_tagq (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign o_rsp0_vld = i_cvt_href & tag_out.vld & ~tag_out.own;
  assign o_rsp1_vld = i_cvt_href & tag_out.vld &  tag_out.own;
  assign o_rsp_l    = i_cvt_l;
  assign o_rsp_m    = i_cvt_m;
  assign o_rsp_s    = i_cvt_s;

  assign err_tag_set  = i_cvt_href != tag_out.vld;
  assign err_long_set = acc & ~last_beat & (beat_cnt == CW'(MAX_BURST - 1));

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err <= '0;
    end else begin
      o_err[ERR_TAG]  <= (o_err[ERR_TAG]  & ~i_err_clr) | err_tag_set;
      o_err[ERR_LONG] <= (o_err[ERR_LONG] & ~i_err_clr) | err_long_set;
    end
  end

endmodule
